// File: rtl/icache_direct_if.sv
// Fetch-side and memory-side signal bundle for icache_direct.
// The cache uses the slave modport; the fetch stage and memory controller use master.
interface icache_direct_if;
  // Fetch handshake: imemREN is the request and ihit completes it. The requester
  // holds imemREN/imemaddr until ihit. Memory handshake: iREN is the request, and a
  // transfer completes on the first rising edge with iREN && !iwait, when iload is sampled.
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;

  modport slave (
    input  imemREN, imemaddr, iload, iwait,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iload, iwait,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with blocking single-word fills.
// Define ICACHE_STATS_EN to add the hit_count/miss_count outputs.
module icache_direct #(
  parameter int NSETS = 16
) (
  input  logic CLK,
  input  logic nRST,
  icache_direct_if.slave bus,
  output logic state_dbg
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(NSETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state;
  logic [NSETS-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [NSETS];
  logic [31:0]       data_q [NSETS];
  logic [29:0]       fill_addr_q;
  logic              iren_q;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic              hit;
  logic              start_fill;
  logic              fill_done;
  logic              unused_addr_bits;

  assign req_idx  = bus.imemaddr[IDX_W+1:2];
  assign req_tag  = bus.imemaddr[31:IDX_W+2];
  assign fill_idx = fill_addr_q[IDX_W-1:0];
  assign fill_tag = fill_addr_q[29:IDX_W];
  assign unused_addr_bits = ^bus.imemaddr[1:0];

  // A hit is only reported in IDLE, so the cycle of a fill write never shows ihit.
  assign hit        = (state == IDLE) && bus.imemREN && valid_q[req_idx]
                      && (tag_q[req_idx] == req_tag);
  assign start_fill = (state == IDLE) && bus.imemREN && !hit;
  assign fill_done  = (state == FILL) && !bus.iwait;

  assign bus.ihit     = hit;
  assign bus.imemload = hit ? data_q[req_idx] : 32'd0;
  assign bus.iREN     = iren_q;
  assign bus.iaddr    = {fill_addr_q, 2'b00};
  assign state_dbg    = (state == FILL);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      valid_q     <= '0;
      fill_addr_q <= '0;
      iren_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_fill) begin
            fill_addr_q <= bus.imemaddr[31:2];
            iren_q      <= 1'b1;
            state       <= FILL;
          end
        end
        FILL: begin
          // The fill runs to completion regardless of what the fetch stage does meanwhile.
          if (!bus.iwait) begin
            valid_q[fill_idx] <= 1'b1;
            iren_q            <= 1'b0;
            state             <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          iren_q <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.iload;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit)        hit_count  <= hit_count + 32'd1;
      if (start_fill) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/icache_direct.md
# icache_direct

Direct-mapped, read-only instruction cache between the pipeline's instruction-fetch port and the memory controller's instruction port. Serves the fetch stage's imemREN/imemaddr requests, returns imemload with a one-cycle-visible ihit on a tag match, and on a miss runs a blocking single-word fill from memory. The fetch stage stalls the PC and IF/ID register on !ihit, so the cache never accepts a second request while a fill is outstanding.

## Interface
- NSETS, 16: number of one-word frames; power of two, 2..256; IDX_W = log2(NSETS), TAG_W = 30 - IDX_W.
- CLK  in  1  rising-edge clock.
- nRST  in  1  reset, asynchronous, active-low.
- imemREN  in  1  fetch request from datapath.
- imemaddr  in  32  byte address; [1:0] ignored, [IDX_W+1:2] index, [31:IDX_W+2] tag.
- ihit  out  1  requested word valid on imemload this cycle.
- imemload  out  32  instruction word; 0 when ihit low.
- iREN  out  1  memory read request.
- iaddr  out  32  memory word address, [1:0] forced 0.
- iload  in  32  memory read data, valid when iREN && !iwait.
- iwait  in  1  memory busy; fill completes on first cycle iREN && !iwait.

## Operation
- Storage per frame: valid bit, TAG_W tag, 32-bit data. All valid bits cleared on reset; tag/data not reset.
- FSM states: IDLE, FILL.
- IDLE: hit = imemREN && valid[idx] && tag[idx]==addr tag. On hit: ihit=1, imemload=data[idx]. On imemREN && !hit: latch imemaddr into fill_addr, go FILL. imemREN=0: ihit=0, stay IDLE.
- FILL: iREN=1, iaddr={fill_addr[31:2],2'b00}, ihit=0. When !iwait: write data[fill idx]=iload, tag=fill tag, valid=1; go IDLE. While iwait: hold.
- Fill always completes once begun, even if imemREN drops or imemaddr changes; next IDLE cycle re-evaluates the current address (may hit, or start a new fill).
- No write port, no invalidate; self-modifying code unsupported.
- Conflicting addresses with same index evict each other; latest fill wins.

## Timing
- Reset values: state IDLE, ihit 0, imemload 0, iREN 0, iaddr 0, all valid 0.
- Hit: combinational, same cycle as request (zero added latency).
- Miss: cycle 0 detect (ihit 0), cycle 1 iREN asserted; fill with memory returning at cycle 1+W (W wait cycles) writes on that edge; ihit asserted at cycle 2+W. Miss penalty = W+2 cycles.
- iREN never asserted in IDLE; deasserted on the same edge the fill is written.
- iload sampled only on the completing edge; iload during iwait is don't-care.
- nRST asserted mid-FILL: state IDLE, iREN 0 immediately (asynchronous), the pending fill is discarded, no frame written.

## Configuration
- ICACHE_STATS_EN defined: adds outputs hit_count (out, 32) and miss_count (out, 32). hit_count +1 on every IDLE cycle with ihit=1; miss_count +1 on each IDLE->FILL transition. Both reset to 0, wrap at 2^32. A fill completion does not count as a hit; the following hit cycle does.
- Undefined: ports and counters absent; functionality otherwise identical.

## Test plan
- Reset then imemREN=1, imemaddr=0x0000_0040, iwait=0 for 1 cycle then low, iload=0x2001_0005 -> ihit 0 for 2 cycles, iREN at cycle 1 with iaddr 0x40, ihit=1 imemload=0x2001_0005 at cycle 2; repeat read 0x40 -> ihit same cycle.
- Conflict: NSETS=16, fill 0x0000_0000 then request 0x0000_0040 (same idx 0) -> miss, refill; re-request 0x0 -> miss again.
- Wait states: iwait=1 for 5 cycles on a miss -> iREN held 5+1 cycles, iaddr stable, ihit only after fill edge, total penalty 7 cycles.
- Abandon: miss on 0x100, drop imemREN and change imemaddr to 0x200 during FILL -> fill of 0x100 completes; later 0x100 hits, 0x200 misses.
- Reset mid-fill: assert nRST low with iwait=1 during FILL -> iREN 0 immediately; after release, request previously hit address -> miss (valid cleared).
- With ICACHE_STATS_EN: 1 miss + 3 hits on 0x40 -> miss_count=1, hit_count=3; without macro, build succeeds and ports absent.
